// File: rtl/image_writer_if.sv
// Flat monochrome image bus: streamed load, single-pixel write and clear requests
// in one direction, and the frame buffer plus status flags in the other.
interface image_writer_if #(
    parameter int unsigned WIDTH  = 390,
    parameter int unsigned HEIGHT = 80
);
    logic                      start;
    logic                      in_valid;
    logic                      in_bit;
    logic                      in_ready;
    logic                      wr_en;
    logic [15:0]               wr_row;
    logic [15:0]               wr_col;
    logic                      wr_data;
    logic                      clear;
    logic [WIDTH*HEIGHT-1:0]   image;
    logic                      busy;
    logic                      frame_done;
    logic                      err;

    modport master (
        output start, in_valid, in_bit, wr_en, wr_row, wr_col, wr_data, clear,
        input  in_ready, image, busy, frame_done, err
    );

    modport slave (
        input  start, in_valid, in_bit, wr_en, wr_row, wr_col, wr_data, clear,
        output in_ready, image, busy, frame_done, err
    );
endinterface

// File: rtl/image_writer.sv
// Producer side of the flat image bus: holds a WIDTH x HEIGHT 1bpp frame buffer filled by
// a streamed raster load, single-pixel writes or a row-per-cycle clear.
module image_writer #(
    parameter int unsigned WIDTH  = 390,
    parameter int unsigned HEIGHT = 80
) (
    input logic           clk,
    input logic           reset,
    image_writer_if.slave bus
);
    localparam int unsigned NumPix  = WIDTH * HEIGHT;
    localparam int unsigned IdxW    = $clog2(NumPix);
    localparam logic [15:0] LastRow = 16'(HEIGHT - 1);
    localparam logic [15:0] LastCol = 16'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StClear} state_e;

    state_e              state_q, state_d;
    logic [15:0]         cnt_row_q, cnt_row_d;
    logic [15:0]         cnt_col_q, cnt_col_d;
    logic [NumPix-1:0]   image_q, image_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                err_q, err_d;

    logic                wr_in_range;
    logic [IdxW-1:0]     wr_idx;
    logic [IdxW-1:0]     stream_idx;
    logic [IdxW-1:0]     row_base;

    // Truncation to IdxW is safe: each index is only used once its operands are in range.
    assign wr_in_range = (bus.wr_row < 16'(HEIGHT)) && (bus.wr_col < 16'(WIDTH));
    assign wr_idx      = IdxW'(bus.wr_row) * IdxW'(WIDTH) + IdxW'(bus.wr_col);
    assign row_base    = IdxW'(cnt_row_q) * IdxW'(WIDTH);
    assign stream_idx  = row_base + IdxW'(cnt_col_q);

    always_comb begin
        state_d      = state_q;
        cnt_row_d    = cnt_row_q;
        cnt_col_d    = cnt_col_q;
        image_d      = image_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.clear) begin
                    state_d   = StClear;
                    cnt_row_d = '0;
                    err_d     = bus.wr_en;
                end else if (bus.start) begin
                    state_d   = StLoad;
                    cnt_row_d = '0;
                    cnt_col_d = '0;
                    err_d     = bus.wr_en;
                end else if (bus.wr_en) begin
                    if (wr_in_range) begin
                        image_d[wr_idx] = bus.wr_data;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            StLoad: begin
                err_d = bus.wr_en;
                // A restart discards any bit offered in the same cycle.
                if (bus.start) begin
                    cnt_row_d = '0;
                    cnt_col_d = '0;
                end else if (bus.in_valid) begin
                    image_d[stream_idx] = bus.in_bit;
                    if (cnt_col_q == LastCol) begin
                        cnt_col_d = '0;
                        if (cnt_row_q == LastRow) begin
                            cnt_row_d    = '0;
                            state_d      = StIdle;
                            frame_done_d = 1'b1;
                        end else begin
                            cnt_row_d = cnt_row_q + 16'd1;
                        end
                    end else begin
                        cnt_col_d = cnt_col_q + 16'd1;
                    end
                end
            end

            StClear: begin
                err_d = bus.wr_en;
                image_d[row_base +: WIDTH] = '0;
                if (cnt_row_q == LastRow) begin
                    cnt_row_d = '0;
                    state_d   = StIdle;
                end else begin
                    cnt_row_d = cnt_row_q + 16'd1;
                end
            end

            default: state_d = StIdle;
        endcase

        in_ready_d = (state_d == StLoad);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_row_q    <= '0;
            cnt_col_q    <= '0;
            image_q      <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_row_q    <= cnt_row_d;
            cnt_col_q    <= cnt_col_d;
            image_q      <= image_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign bus.image      = image_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.err        = err_q;
endmodule

// File: doc/image_writer.md
# image_writer

Producer side of the flat monochrome image bus. Holds a WIDTH×HEIGHT one-bit-per-pixel frame buffer and drives it as a flat `image` vector to the pixel-lookup block, which reads pixel (row, column) at bit index row*WIDTH + column. The buffer is filled in one of three ways:
- a streamed raster load with a valid/ready handshake;
- random single-pixel writes;
- a row-sequential clear.

## Interface

- WIDTH, 390, pixels per row (columns)
- HEIGHT, 80, rows per frame
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin streamed frame load at pixel (0,0)
- in_valid  in  1  streamed pixel bit present
- in_bit  in  1  streamed pixel value
- in_ready  out  1  writer accepts a streamed bit this cycle
- wr_en  in  1  single-pixel write strobe
- wr_row  in  16  row of single-pixel write
- wr_col  in  16  column of single-pixel write
- wr_data  in  1  value of single-pixel write
- clear  in  1  request full-frame clear
- image  out  WIDTH*HEIGHT  frame buffer; bit row*WIDTH+col = pixel (row,col)
- busy  out  1  high in LOAD or CLEAR
- frame_done  out  1  one-cycle pulse when a streamed frame completes
- err  out  1  one-cycle pulse on a rejected single-pixel write

## Operation

- States are IDLE, LOAD and CLEAR. Internal counters are cnt_row (16 bit) and cnt_col (16 bit).
- **Reset:**
  - state is IDLE;
  - image is all 0 in one cycle;
  - counters are 0;
  - in_ready, busy, frame_done and err are all 0.
- **IDLE priority, highest first:** clear, then start, then wr_en. Only the highest-priority active request is acted on.
  - A lower request in the same cycle is dropped with no err.
  - The only exception is wr_en while clear or start is taken, which pulses err.
- **clear in IDLE:**
  - Go to CLEAR with cnt_row = 0.
  - Each cycle in CLEAR zeroes row cnt_row (WIDTH bits), then increments cnt_row.
  - After row HEIGHT-1 is zeroed, go to IDLE. CLEAR lasts exactly HEIGHT cycles.
- **start in IDLE:** go to LOAD with cnt_row = cnt_col = 0.
- **LOAD:**
  - in_ready is 1 for as long as the state is LOAD.
  - Accept is in_valid && in_ready. On accept, write in_bit to image[cnt_row*WIDTH+cnt_col].
  - After each accept, cnt_col increments. At WIDTH-1, cnt_col wraps to 0 and cnt_row increments.
  - An accept at (HEIGHT-1, WIDTH-1) goes to IDLE and pulses frame_done.
  - in_valid low stalls the load with no state change.
- **start while in LOAD:** restart at (0,0). Already-written pixels are kept. A bit accepted in that same cycle is discarded.
- **clear while in LOAD or CLEAR:** ignored.
- **start while in CLEAR:** ignored.
- **wr_en in IDLE (not preempted):**
  - If wr_row < HEIGHT and wr_col < WIDTH, write wr_data to image[wr_row*WIDTH+wr_col].
  - Otherwise pulse err and leave image unchanged.
- **wr_en while busy:** no write, pulse err.
- **Index arithmetic:** row*WIDTH+col is computed at a width of at least ceil(log2(WIDTH*HEIGHT)) bits. Range checks are unsigned comparisons on the full 16-bit inputs.
- **Outputs outside LOAD:** in_bit and in_valid are don't-care.

## Timing

- All outputs are registered; there are no combinational paths from inputs to outputs.
- A write on edge N is visible on image after edge N. This applies to stream, single-pixel and clear writes.
- **busy and in_ready:**
  - Both rise after the edge that samples start (in_ready) or clear (busy).
  - in_ready equals (state == LOAD).
- **frame_done:**
  - High for exactly the one cycle after the edge accepting the last pixel.
  - in_ready and busy are 0 in that same cycle.
  - A new start may be sampled in the frame_done cycle.
- **err:** high for exactly the one cycle after the edge that sampled the rejected wr_en.
- **Throughput:**
  - Streamed load: one pixel per cycle; minimum WIDTH*HEIGHT cycles per frame (31200 at defaults).
  - Clear: HEIGHT cycles.
- **Reset mid-LOAD or mid-CLEAR:** after the next edge, state is IDLE, image is 0 and all flags are 0. No frame_done is produced.

## Test plan

- Reset, then hold 5 cycles → image == 0, in_ready = busy = frame_done = err = 0.
- Single-pixel writes:
  - (0,0,1), (0,10,1) and (70,0,1) → image bits 0, 10 and 27300 set, all others 0.
  - (0,10,0) → bit 10 cleared.
- Rejected writes:
  - wr (80,0,1) and wr (0,390,1) → each gives a one-cycle err, image unchanged.
  - wr_en during CLEAR → err, no write.
- Streamed load:
  - Stimulus: start, then 31200 bits with in_bit = index%2 and in_valid low every 7th cycle.
  - Required: image bit k == k%2 for all k; exactly one frame_done, one cycle after the final accept; in_ready = 0 afterwards.
- Clear after a full load:
  - busy high for exactly 80 cycles, then image == 0.
  - start asserted mid-clear has no effect.
- Abort cases:
  - start asserted at the 500th accept → reload from (0,0); pixels 0–499 are overwritten by the new stream.
  - Separately, reset at the 1000th accept → image == 0 and IDLE on the next cycle, no frame_done.
